fifo_wr_arbiter: RTL and testbench

//  Shares the write port of one dual-clock FIFO among N_REQ requesters, all in the FIFO write-clock domain.

---
 rtl/fifo_wr_arbiter_pkg.sv | 11 +
 rtl/fifo_wr_arbiter_if.sv | 18 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 55 +++++
 tb/tb_fifo_wr_arbiter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared state type and width/pointer helpers for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  // wraps at n, not at a power of two, so odd requester counts rotate correctly
  function automatic int wrap_inc(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester beats in, tagged FIFO write port and lock status out
interface fifo_wr_arbiter_if #(parameter int N_REQ = 4, parameter int DATA_W = 32);
  import fifo_arb_pkg::*;
  localparam int ID_W = id_width(N_REQ);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_last;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0] req_ready;
  logic fifo_wfull;
  logic fifo_winc;
  logic [ID_W+DATA_W-1:0] fifo_wdata;
  logic locked;
  logic [ID_W-1:0] owner_id;
  modport master (output req_valid, req_last, req_data, fifo_wfull,
                  input req_ready, fifo_winc, fifo_wdata, locked, owner_id);
  modport slave (input req_valid, req_last, req_data, fifo_wfull,
                 output req_ready, fifo_winc, fifo_wdata, locked, owner_id);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: first valid requester searching upward from prio_ptr with wrap at N_REQ
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  prio_ptr,
  output logic             found,
  output logic [ID_W-1:0]  winner_id,
  output logic [N_REQ-1:0] winner_onehot
);
  int idx;
  always_comb begin
    found = 1'b0;
    winner_id = '0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(prio_ptr) + k >= N_REQ) ? int'(prio_ptr) + k - N_REQ : int'(prio_ptr) + k;
      if (!found && valid[idx]) begin
        found = 1'b1;
        winner_id = ID_W'(idx);
      end
    end
    winner_onehot = found ? N_REQ'(1) << winner_id : '0;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-atomic round-robin sharing of one FIFO write port, beats tagged with source id
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int ID_W = id_width(N_REQ);
  arb_state_e state, state_n;
  logic [ID_W-1:0] prio_ptr, prio_n, owner, owner_n, win_id, pick_ptr;
  logic [N_REQ-1:0] grant, pick_valid;
  logic found, is_lk, win_last;
  assign is_lk = state == ARB_LOCKED;
  // while locked, searching from the owner over its own valid alone pins the grant to it
  assign pick_valid = is_lk ? bus.req_valid & (N_REQ'(1) << owner) : bus.req_valid;
  assign pick_ptr = is_lk ? owner : prio_ptr;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid(pick_valid),
    .prio_ptr(pick_ptr),
    .found(found),
    .winner_id(win_id),
    .winner_onehot(grant)
  );
  assign bus.fifo_winc = found & ~bus.fifo_wfull & ~rst;
  assign bus.req_ready = bus.fifo_winc ? grant : '0;
  assign bus.fifo_wdata = bus.fifo_winc ? {win_id, bus.req_data[int'(win_id)*DATA_W +: DATA_W]} : '0;
  assign bus.locked = is_lk & ~rst;
  assign bus.owner_id = rst ? '0 : owner;
  assign win_last = bus.req_last[win_id];
  always_comb begin
    state_n = state;
    prio_n = prio_ptr;
    owner_n = owner;
    if (bus.fifo_winc) begin
      owner_n = win_id;
      state_n = win_last ? ARB_IDLE : ARB_LOCKED;
      prio_n = win_last ? ID_W'(wrap_inc(int'(win_id), N_REQ)) : prio_ptr;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      prio_ptr <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      prio_ptr <= prio_n;
      owner <= owner_n;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random packet traffic on 4- and 3-requester arbiters against a round-robin reference
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_W(DW)) b4 ();
  fifo_wr_arbiter_if #(.N_REQ(3), .DATA_W(DW)) b3 ();
  fifo_wr_arbiter #(.N_REQ(4), .DATA_W(DW)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  fifo_wr_arbiter #(.N_REQ(3), .DATA_W(DW)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
  logic [3:0] v[2], l[2];
  logic [7:0] d[2][4];
  int rem[2][4];
  bit wf[2];
  bit rnd;
  int m_ptr[2], m_own[2];
  bit m_lk[2];
  logic [15:0] g_rdy[2], g_wd[2], g_own[2];
  logic g_wc[2], g_lk[2];
  int n_chk, n_err;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input int u);
    int n = u ? 3 : 4;
    if (wf[u] || rst) return -1;
    if (m_lk[u]) return v[u][m_own[u]] ? m_own[u] : -1;
    for (int k = 0; k < n; k++) if (v[u][(m_ptr[u] + k) % n]) return (m_ptr[u] + k) % n;
    return -1;
  endfunction
  task automatic model(input int u);
    int n = u ? 3 : 4;
    int e;
    string s = u ? "n3" : "n4";
    if (rst) begin
      m_ptr[u] = 0;
      m_own[u] = 0;
      m_lk[u] = 0;
    end
    e = pick(u);
    check({s, ".ready"}, g_rdy[u], e < 0 ? 0 : 1 << e);
    check({s, ".winc"}, g_wc[u], e >= 0);
    check({s, ".wdata"}, g_wd[u], e < 0 ? 0 : (e << 8) | d[u][e]);
    check({s, ".locked"}, g_lk[u], m_lk[u]);
    check({s, ".owner"}, g_own[u], m_own[u]);
    if (e >= 0) begin
      m_own[u] = e;
      m_lk[u] = !l[u][e];
      if (l[u][e]) m_ptr[u] = (e + 1) % n;
    end
    if (rnd) begin
      for (int i = 0; i < n; i++) begin
        if (e == i) begin
          rem[u][i]--;
          v[u][i] = 1'b0;
          if (rem[u][i] > 0 && $urandom_range(0, 3) != 0) begin
            v[u][i] = 1'b1;
            d[u][i] = 8'($urandom);
            l[u][i] = rem[u][i] == 1;
          end
        end else if (!v[u][i] && $urandom_range(0, 1) == 1) begin
          if (rem[u][i] == 0) rem[u][i] = $urandom_range(1, 3);
          v[u][i] = 1'b1;
          d[u][i] = 8'($urandom);
          l[u][i] = rem[u][i] == 1;
        end
      end
      wf[u] = $urandom_range(0, 3) == 0;
    end
  endtask
  task automatic cycle(input bit r);
    @(negedge clk);
    rst = r;
    b4.req_valid = v[0];
    b4.req_last = l[0];
    b4.fifo_wfull = wf[0];
    for (int i = 0; i < 4; i++) b4.req_data[i*DW +: DW] = d[0][i];
    b3.req_valid = v[1][2:0];
    b3.req_last = l[1][2:0];
    b3.fifo_wfull = wf[1];
    for (int i = 0; i < 3; i++) b3.req_data[i*DW +: DW] = d[1][i];
    #1;
    g_rdy[0] = 16'(b4.req_ready);
    g_wc[0] = b4.fifo_winc;
    g_wd[0] = 16'(b4.fifo_wdata);
    g_lk[0] = b4.locked;
    g_own[0] = 16'(b4.owner_id);
    g_rdy[1] = 16'(b3.req_ready);
    g_wc[1] = b3.fifo_winc;
    g_wd[1] = 16'(b3.fifo_wdata);
    g_lk[1] = b3.locked;
    g_own[1] = 16'(b3.owner_id);
    model(0);
    model(1);
  endtask
  logic [15:0] seq[5] = '{16'h010, 16'h111, 16'h212, 16'h313, 16'h010};
  initial begin
    bit hit;
    n_chk = 0;
    n_err = 0;
    rnd = 1'b0;
    for (int u = 0; u < 2; u++) begin
      v[u] = u ? 4'h7 : 4'hF;
      l[u] = 4'hF;
      wf[u] = 1'b0;
      m_ptr[u] = 0;
      m_own[u] = 0;
      m_lk[u] = 0;
      for (int i = 0; i < 4; i++) begin
        d[u][i] = 8'(8'h10 + i);
        rem[u][i] = 0;
      end
    end
    cycle(1);
    cycle(1);
    check("rst_winc", g_wc[0], 0);
    for (int k = 0; k < 5; k++) begin
      cycle(0);
      check("rr_seq", g_wd[0], seq[k]);
    end
    rnd = 1'b1;
    for (int k = 0; k < 3000; k++) cycle($urandom_range(0, 99) == 0);
    hit = 0;
    for (int k = 0; k < 500 && !hit; k++) begin
      cycle(0);
      hit = m_lk[1];
    end
    check("find_lock", hit, 1);
    cycle(1);
    check("midpkt_rst_winc", g_wc[1], 0);
    check("midpkt_rst_locked", g_lk[1], 0);
    for (int k = 0; k < 50; k++) cycle(0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
